// File: rtl/sat_counter_pht.sv
// sat_counter_pht: pattern history table of saturating counters with a registered
// write-first lookup port, per-entry train/clear, and a multi-cycle flush sweep.
module sat_counter_pht #(
  parameter int CNT_W = 2,
  parameter int IDX_W = 8,
  parameter int DEPTH = 256,
  parameter int INIT  = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             feedback,
  input  logic             get,
  input  logic [IDX_W-1:0] get_index,
  input  logic             set,
  input  logic [IDX_W-1:0] set_index,
  input  logic             clear,
  input  logic [IDX_W-1:0] clear_index,
  input  logic             flush,
  output logic             prediction,
  output logic [CNT_W-1:0] confidence,
  output logic             pred_valid,
  output logic             busy
);

  localparam logic [CNT_W-1:0] INIT_V   = CNT_W'(INIT);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);
  localparam logic [IDX_W-1:0] LAST_PTR = IDX_W'(DEPTH - 1);
  localparam logic [IDX_W-1:0] PTR_ONE  = IDX_W'(1'b1);
  localparam logic [IDX_W-1:0] PTR_ZERO = {IDX_W{1'b0}};

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } state_t;

  state_t           state_r, state_nxt_s;
  logic [IDX_W-1:0] ptr_r, ptr_nxt_s;
  logic [CNT_W-1:0] mem_r     [DEPTH];
  logic [CNT_W-1:0] mem_nxt_s [DEPTH];
  logic [CNT_W-1:0] rd_val_s;
  logic [CNT_W-1:0] conf_r;
  logic             valid_r;
  logic             get_ok_s, set_ok_s, clr_ok_s, sweep_we_s;

  function automatic logic [CNT_W-1:0] sat_step(input logic [CNT_W-1:0] val, input logic up);
    logic [CNT_W-1:0] res;
    if (up) begin
      res = (val == CNT_MAX) ? val : val + CNT_ONE;
    end else begin
      res = (val == CNT_ZERO) ? val : val - CNT_ONE;
    end
    return res;
  endfunction

  // Sequencer: flush has priority in IDLE; SWEEP masks every request.
  always_comb begin
    state_nxt_s = state_r;
    ptr_nxt_s   = ptr_r;
    get_ok_s    = 1'b0;
    set_ok_s    = 1'b0;
    clr_ok_s    = 1'b0;
    sweep_we_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (flush) begin
          state_nxt_s = SWEEP;
          ptr_nxt_s   = PTR_ZERO;
        end else begin
          get_ok_s = get;
          clr_ok_s = clear;
          set_ok_s = set & ~(clear & (clear_index == set_index));
        end
      end
      SWEEP: begin
        sweep_we_s = 1'b1;
        if (ptr_r == LAST_PTR) begin
          state_nxt_s = IDLE;
          ptr_nxt_s   = PTR_ZERO;
        end else begin
          ptr_nxt_s = ptr_r + PTR_ONE;
        end
      end
      default: begin
        state_nxt_s = IDLE;
        ptr_nxt_s   = PTR_ZERO;
      end
    endcase
  end

  // Per-entry next value; out-of-range indices never match a decoded entry.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      if (sweep_we_s && (ptr_r == IDX_W'(i))) begin
        mem_nxt_s[i] = INIT_V;
      end else if (clr_ok_s && (clear_index == IDX_W'(i))) begin
        mem_nxt_s[i] = INIT_V;
      end else if (set_ok_s && (set_index == IDX_W'(i))) begin
        mem_nxt_s[i] = sat_step(mem_r[i], feedback);
      end else begin
        mem_nxt_s[i] = mem_r[i];
      end
    end
  end

  // Write-first lookup mux over post-edge values; misses return INIT.
  always_comb begin
    rd_val_s = INIT_V;
    for (int i = 0; i < DEPTH; i++) begin
      rd_val_s = (get_index == IDX_W'(i)) ? mem_nxt_s[i] : rd_val_s;
    end
  end

  // Counter storage, reset as a whole.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= INIT_V;
      end
    end else begin
      mem_r <= mem_nxt_s;
    end
  end

  // Sequencer state, sweep pointer and registered lookup result.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
      ptr_r   <= PTR_ZERO;
      conf_r  <= INIT_V;
      valid_r <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      ptr_r   <= ptr_nxt_s;
      valid_r <= get_ok_s;
      conf_r  <= get_ok_s ? rd_val_s : conf_r;
    end
  end

  assign confidence = conf_r;
  assign prediction = conf_r[CNT_W-1];
  assign pred_valid = valid_r;
  assign busy       = (state_r == SWEEP);

endmodule

// File: tb/tb_sat_counter_pht.sv
// Randomised scoreboard bench for sat_counter_pht: an array-based reference model
// queues expected lookups; a negedge monitor checks every cycle's outputs.
module tb_sat_counter_pht;
  localparam int CNT_W = 2;
  localparam int IDX_W = 5;
  localparam int DEPTH = 16;
  localparam int INIT  = 1;
  localparam int MAXC  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             feedback = 1'b0, get = 1'b0, set = 1'b0, clear = 1'b0, flush = 1'b0;
  logic [IDX_W-1:0] get_index = '0, set_index = '0, clear_index = '0;
  logic             prediction, pred_valid, busy;
  logic [CNT_W-1:0] confidence;

  int model [DEPTH];
  int sweep_left = 0;
  int exp_q [$];
  int exp_conf = INIT;
  bit exp_busy = 1'b0;
  int tests = 0;
  int fails = 0;

  sat_counter_pht #(.CNT_W(CNT_W), .IDX_W(IDX_W), .DEPTH(DEPTH), .INIT(INIT)) dut (
    .clk(clk), .reset(reset), .feedback(feedback),
    .get(get), .get_index(get_index),
    .set(set), .set_index(set_index),
    .clear(clear), .clear_index(clear_index),
    .flush(flush),
    .prediction(prediction), .confidence(confidence),
    .pred_valid(pred_valid), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: effect of one rising edge given the currently held inputs.
  task automatic model_edge();
    int si, ci, gi;
    si = int'(set_index);
    ci = int'(clear_index);
    gi = int'(get_index);
    if (sweep_left > 0) begin
      model[DEPTH - sweep_left] = INIT;
      sweep_left--;
    end else if (flush) begin
      sweep_left = DEPTH;
    end else begin
      if (clear && ci < DEPTH) model[ci] = INIT;
      if (set && si < DEPTH && !(clear && ci == si)) begin
        if (feedback) model[si] = (model[si] + 1 > MAXC) ? MAXC : model[si] + 1;
        else          model[si] = (model[si] - 1 < 0) ? 0 : model[si] - 1;
      end
      if (get) exp_q.push_back((gi < DEPTH) ? model[gi] : INIT);
    end
    exp_busy = (sweep_left > 0);
  endtask

  task automatic step(input bit g, input int gi, input bit s, input int si,
                      input bit fb, input bit c, input int ci, input bit f);
    get = g; get_index = IDX_W'(gi);
    set = s; set_index = IDX_W'(si); feedback = fb;
    clear = c; clear_index = IDX_W'(ci);
    flush = f;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle();             step(1'b0, 0, 1'b0, 0, 1'b0, 1'b0, 0, 1'b0); endtask
  task automatic rd(input int i);    step(1'b1, i, 1'b0, 0, 1'b0, 1'b0, 0, 1'b0); endtask
  task automatic train(input int i, input bit fb); step(1'b0, 0, 1'b1, i, fb, 1'b0, 0, 1'b0); endtask

  task automatic do_reset();
    reset = 1'b1;
    for (int i = 0; i < DEPTH; i++) model[i] = INIT;
    sweep_left = 0;
    exp_busy = 1'b0;
    exp_q.delete();
    exp_conf = INIT;
    #1;
    chk("busy_async_reset", busy, 0);
    chk("valid_async_reset", pred_valid, 0);
    @(negedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic wait_sweep(input string name);
    int n;
    n = 0;
    while (busy && n < 200) begin
      idle();
      n++;
    end
    chk(name, busy, 0);
  endtask

  // Monitor: every negedge compares valid/busy and the looked-up value.
  always @(negedge clk) begin
    bit exp_v;
    exp_v = (exp_q.size() > 0);
    chk("pred_valid", pred_valid, exp_v);
    chk("busy", busy, exp_busy);
    if (exp_v) exp_conf = exp_q.pop_front();
    chk("confidence", confidence, exp_conf);
    chk("prediction", prediction, exp_conf >> (CNT_W - 1));
  end

  initial begin
    int cnt;
    do_reset();

    rd(5);
    idle();

    for (int k = 0; k < 4; k++) train(3, 1'b1);
    rd(3);
    for (int k = 0; k < 3; k++) train(3, 1'b0);
    rd(3);
    train(3, 1'b0);
    rd(3);

    step(1'b1, 7, 1'b1, 7, 1'b1, 1'b0, 0, 1'b0);
    idle();

    for (int k = 0; k < 3; k++) train(9, 1'b1);
    step(1'b0, 0, 1'b1, 9, 1'b1, 1'b1, 9, 1'b0);
    rd(9);
    train(9, 1'b1);
    step(1'b0, 0, 1'b1, 2, 1'b1, 1'b1, 9, 1'b0);
    rd(2);
    rd(9);

    step(1'b0, 0, 1'b1, 20, 1'b1, 1'b1, 25, 1'b0);
    rd(20);
    rd(31);

    for (int k = 0; k < 400; k++) begin
      step(1'($urandom_range(0, 1)), int'($urandom_range(0, 31)),
           1'($urandom_range(0, 1)), int'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 7) == 0), int'($urandom_range(0, 31)),
           ($urandom_range(0, 59) == 0));
    end
    wait_sweep("random_sweep_end");

    for (int k = 0; k < 3; k++) begin
      train(0, 1'b1);
      train(15, 1'b1);
    end
    rd(0);
    rd(15);
    step(1'b0, 0, 1'b0, 0, 1'b0, 1'b0, 0, 1'b1);
    cnt = 0;
    while (busy && cnt < 200) begin
      cnt++;
      step(1'b1, int'($urandom_range(0, 15)), 1'b1, int'($urandom_range(0, 15)), 1'b1,
           1'($urandom_range(0, 1)), int'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
    end
    chk("busy_length", cnt, DEPTH);
    rd(0);
    rd(15);

    for (int k = 0; k < 3; k++) begin
      train(10, 1'b1);
      train(12, 1'b0);
    end
    step(1'b0, 0, 1'b0, 0, 1'b0, 1'b0, 0, 1'b1);
    for (int k = 0; k < 5; k++) idle();
    do_reset();
    for (int i = 0; i < DEPTH; i++) rd(i);

    step(1'b0, 0, 1'b0, 0, 1'b0, 1'b0, 0, 1'b1);
    for (int k = 0; k < 5; k++) idle();
    do_reset();
    step(1'b0, 0, 1'b0, 0, 1'b0, 1'b0, 0, 1'b1);
    chk("flush_after_reset", busy, 1);
    wait_sweep("second_sweep_end");
    rd(4);

    idle();
    idle();
    chk("queue_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
